// File: rtl/gsim_converge_drain.sv
// Convergence monitor behind the Gauss-Seidel core. It keeps the latest sweep of x estimates,
// waits for CONV_SWEEPS consecutive quiet sweeps (or MAX_SWEEPS), then drains the frozen vector.
//
// state   | meaning
// COLLECT | accept x samples, track the per-sweep max |delta|
// DRAIN   | present buffered vector, advance on out_ready
// DONE    | drain finished; wait for clr/reset
module gsim_converge_drain #(
   parameter int N           = 16,
   parameter int W           = 32,
   parameter int TOL         = 16,
   parameter int CONV_SWEEPS = 2,
   parameter int MAX_SWEEPS  = 100,
   parameter int IW          = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          x_valid,
   input  logic [W-1:0]  x_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          done,
   output logic          timeout,
   output logic [7:0]    sweep_cnt
);
   typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
   localparam logic [W-1:0]  TOL_V    = W'(TOL);

   state_t            state, state_d;
   logic [W-1:0]      mem [N];
   logic [IW-1:0]     wr_idx, rd_idx;
   logic              first_sweep;
   logic [7:0]        conv_cnt;
   logic [W-1:0]      sweep_max;

   logic              restart, accept, sweep_end, sweep_ok, conv_hit, max_hit, beat;
   logic [W-1:0]      old_val, delta, smax_next;
   logic signed [W:0] diff;
   logic [W:0]        diff_abs;
   logic [8:0]        sweep_inc;
   logic [7:0]        conv_inc;

   assign restart   = reset | clr;
   assign accept    = (state == COLLECT) && x_valid;
   assign old_val   = mem[wr_idx];

   // One extra bit keeps the difference of two extreme W-bit values exact.
   assign diff      = $signed({x_in[W-1], x_in}) - $signed({old_val[W-1], old_val});
   assign diff_abs  = diff[W] ? $unsigned(-diff) : $unsigned(diff);
   assign delta     = diff_abs[W] ? '1 : diff_abs[W-1:0];
   assign smax_next = (delta > sweep_max) ? delta : sweep_max;

   assign sweep_end = accept && (wr_idx == LAST_IDX);
   assign sweep_ok  = !first_sweep && (smax_next < TOL_V);
   assign conv_inc  = conv_cnt + 8'd1;
   assign sweep_inc = {1'b0, sweep_cnt} + 9'd1;
   assign conv_hit  = sweep_ok && (conv_inc == 8'(CONV_SWEEPS));
   assign max_hit   = (sweep_inc == 9'(MAX_SWEEPS));
   assign beat      = (state == DRAIN) && out_ready;

   always_comb begin
      state_d = state;
      case (state)
         COLLECT: if (sweep_end && (conv_hit || max_hit)) state_d = DRAIN;
         DRAIN:   if (out_ready && (rd_idx == LAST_IDX)) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      out_valid = (state == DRAIN);
      out_data  = out_valid ? mem[rd_idx] : '0;
      out_idx   = out_valid ? rd_idx : '0;
      out_last  = out_valid && (rd_idx == LAST_IDX);
      done      = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (restart) state <= COLLECT;
      else         state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (restart) begin
         wr_idx      <= '0;
         rd_idx      <= '0;
         first_sweep <= 1'b1;
         conv_cnt    <= '0;
         sweep_max   <= '0;
         sweep_cnt   <= '0;
         timeout     <= 1'b0;
      end else begin
         if (sweep_end) begin
            wr_idx      <= '0;
            sweep_max   <= '0;
            first_sweep <= 1'b0;
            sweep_cnt   <= sweep_inc[8] ? 8'hFF : sweep_inc[7:0];
            conv_cnt    <= sweep_ok ? conv_inc : 8'd0;
            if (!conv_hit && max_hit) timeout <= 1'b1;
         end else if (accept) begin
            wr_idx    <= wr_idx + IW'(1);
            sweep_max <= smax_next;
         end
         if (beat) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IW'(1);
      end
   end

   // Buffer is frozen outside COLLECT and never cleared; first_sweep masks stale contents.
   always_ff @(posedge clk) begin
      if (accept && !restart) mem[wr_idx] <= x_in;
   end
endmodule

// File: tb/tb_gsim_converge_drain.sv
// Directed bench for gsim_converge_drain: sweep-level reference model checked every cycle,
// plus literal expectations for latency, beat order, tolerance edges, timeout and clear.
module tb_gsim_converge_drain;
   localparam int N    = 16;
   localparam int W    = 32;
   localparam int IW   = 4;
   localparam int TOL  = 16;
   localparam int CONV = 2;
   localparam int MAXS = 100;
   localparam longint SAT = 64'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          reset, clr, x_valid, out_ready;
   logic [W-1:0]  x_in;
   logic          out_valid, out_last, done, timeout;
   logic [W-1:0]  out_data;
   logic [IW-1:0] out_idx;
   logic [7:0]    sweep_cnt;

   gsim_converge_drain dut (
      .clk(clk), .reset(reset), .clr(clr), .x_valid(x_valid), .x_in(x_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .done(done), .timeout(timeout),
      .sweep_cnt(sweep_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 collect, 1 drain, 2 done.
   logic [W-1:0] m_buf [N];
   int     m_phase, m_idx, m_rd, m_run, m_sweeps;
   bit     m_first, m_to, m_ok;
   longint m_smax, m_d;

   initial for (int i = 0; i < N; i++) m_buf[i] = '0;

   always @(posedge clk) begin
      if (reset || clr) begin
         m_phase = 0; m_idx = 0; m_rd = 0; m_first = 1; m_run = 0;
         m_smax = 0; m_sweeps = 0; m_to = 0;
      end else if (m_phase == 0 && x_valid) begin
         m_d = longint'($signed(x_in)) - longint'($signed(m_buf[m_idx]));
         if (m_d < 0) m_d = -m_d;
         if (m_d > SAT) m_d = SAT;
         if (m_d > m_smax) m_smax = m_d;
         m_buf[m_idx] = x_in;
         if (m_idx == N - 1) begin
            m_ok = !m_first && (m_smax < TOL);
            m_sweeps++;
            m_first = 0;
            m_run = m_ok ? m_run + 1 : 0;
            m_smax = 0;
            m_idx = 0;
            if (m_ok && m_run == CONV) m_phase = 1;
            else if (m_sweeps == MAXS) begin m_phase = 1; m_to = 1; end
         end else m_idx++;
      end else if (m_phase == 1 && out_ready) begin
         if (m_rd == N - 1) m_phase = 2;
         m_rd = (m_rd + 1) % N;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, m_phase == 1);
         check("done", done, m_phase == 2);
         check("timeout", timeout, m_to);
         check("sweep_cnt", sweep_cnt, (m_sweeps > 255) ? 255 : m_sweeps);
         if (m_phase == 1) begin
            check("out_data", out_data, m_buf[m_rd]);
            check("out_idx", out_idx, m_rd);
            check("out_last", out_last, m_rd == N - 1);
         end
      end
   end

   logic [W-1:0] sv [N];
   logic [W-1:0] ev [N];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < N; i++) sv[i] = i * 32'h0001_0000;
   endtask

   task automatic send_sweep(input int gap_at);
      for (int i = 0; i < N; i++) begin
         if (i == gap_at) begin x_valid = 1'b0; tick(); tick(); end
         x_valid = 1'b1; x_in = sv[i]; tick();
      end
      x_valid = 1'b0;
   endtask

   task automatic drain(input int stall_beat, input int stall_len, input int clr_beat);
      int beats = 0;
      int stalled = 0;
      int cyc = 0;
      while (cyc < 200 && !done) begin
         if (beats == clr_beat) begin
            do_clr();
            check("clr_valid", out_valid, 0);
            check("clr_done", done, 0);
            check("clr_timeout", timeout, 0);
            check("clr_sweep_cnt", sweep_cnt, 0);
            return;
         end
         if (beats == stall_beat && stalled < stall_len) begin
            out_ready = 1'b0;
            stalled++;
            check("stall_idx", out_idx, stall_beat);
            check("stall_data", out_data, ev[stall_beat]);
         end else out_ready = 1'b1;
         if (out_valid && out_ready) begin
            check("beat_idx", out_idx, beats);
            check("beat_data", out_data, ev[beats]);
            check("beat_last", out_last, beats == N - 1);
            beats++;
         end
         tick();
         cyc++;
      end
      out_ready = 1'b1;
      check("beat_count", beats, N);
      check("done_after_drain", done, 1);
      check("valid_after_drain", out_valid, 0);
   endtask

   task automatic scenario_const();
      fill_ramp();
      for (int i = 0; i < N; i++) ev[i] = sv[i];
      send_sweep(-1);
      send_sweep(-1);
      check("s1_no_early_drain", out_valid, 0);
      send_sweep(7);
      check("s1_latency", out_valid, 1);
      drain(-1, 0, -1);
      check("s1_sweep_cnt", sweep_cnt, 3);
      check("s1_timeout", timeout, 0);
   endtask

   initial begin
      reset = 1'b1; clr = 1'b0; x_valid = 1'b0; x_in = '0; out_ready = 1'b1;
      tick(); tick();
      chk_en = 1'b1;
      check("rst_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_sweep_cnt", sweep_cnt, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_data", out_data, 0);
      reset = 1'b0;

      // 1: constant sweeps converge after sweep 3
      scenario_const();

      // 2a: 16 LSB change is not within tolerance
      do_clr();
      fill_ramp();
      send_sweep(-1); send_sweep(-1);
      sv[5] = sv[5] + 32'd16;
      send_sweep(-1);
      check("s2_tol16_no_drain", out_valid, 0);
      send_sweep(-1);
      check("s2_tol16_run1", out_valid, 0);
      send_sweep(-1);
      check("s2_tol16_drain", out_valid, 1);
      for (int i = 0; i < N; i++) ev[i] = sv[i];
      drain(-1, 0, -1);
      check("s2_tol16_sweeps", sweep_cnt, 5);

      // 2b: 15 LSB change is within tolerance
      do_clr();
      fill_ramp();
      send_sweep(-1); send_sweep(-1);
      sv[5] = sv[5] + 32'd15;
      send_sweep(-1);
      check("s2_tol15_drain", out_valid, 1);
      for (int i = 0; i < N; i++) ev[i] = sv[i];
      check("s2_idx5_value", ev[5], 32'h0005_000F);
      drain(-1, 0, -1);
      check("s2_tol15_sweeps", sweep_cnt, 3);

      // 3: backpressure at beat 7
      do_clr();
      fill_ramp();
      for (int i = 0; i < N; i++) ev[i] = sv[i];
      send_sweep(-1); send_sweep(-1); send_sweep(-1);
      drain(7, 5, -1);

      // 4: alternating sweeps never settle, forced drain after sweep 100
      do_clr();
      for (int s = 1; s <= MAXS; s++) begin
         for (int i = 0; i < N; i++) sv[i] = (s % 2 == 1) ? 32'h0 : 32'h0000_0100;
         send_sweep(-1);
         if (s == MAXS - 1) check("s4_no_drain_99", out_valid, 0);
      end
      check("s4_drain", out_valid, 1);
      check("s4_timeout", timeout, 1);
      check("s4_sweep_cnt", sweep_cnt, 100);
      for (int i = 0; i < N; i++) ev[i] = 32'h0000_0100;
      drain(-1, 0, -1);
      check("s4_timeout_held", timeout, 1);

      // 5: extreme difference saturates and resets the run
      do_clr();
      fill_ramp();
      sv[3] = 32'h7FFF_FFFF;
      send_sweep(-1);
      sv[3] = 32'h8000_0000;
      send_sweep(-1);
      check("s5_sat_no_drain", out_valid, 0);
      send_sweep(-1);
      check("s5_run1_no_drain", out_valid, 0);
      send_sweep(-1);
      check("s5_drain", out_valid, 1);
      for (int i = 0; i < N; i++) ev[i] = sv[i];
      drain(-1, 0, -1);
      check("s5_sweep_cnt", sweep_cnt, 4);

      // 6a: clr at beat 4, then a fresh constant run
      do_clr();
      fill_ramp();
      for (int i = 0; i < N; i++) ev[i] = sv[i];
      send_sweep(-1); send_sweep(-1); send_sweep(-1);
      drain(-1, 0, 4);
      scenario_const();

      // 6b: reset in the middle of COLLECT, then a fresh constant run
      do_clr();
      fill_ramp();
      send_sweep(-1);
      for (int i = 0; i < 5; i++) begin x_valid = 1'b1; x_in = sv[i]; tick(); end
      x_valid = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst6_valid", out_valid, 0);
      check("rst6_done", done, 0);
      check("rst6_sweep_cnt", sweep_cnt, 0);
      scenario_const();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
      $fatal(1);
   end
endmodule

// File: doc/gsim_converge_drain.md
Name: gsim_converge_drain

Overview:
- Sits directly downstream of the Gauss-Seidel solver core and consumes its per-cycle x estimates (Q16.16, 32-bit signed).
- Buffers the latest full sweep of N unknowns and compares each new estimate with the previous sweep's value.
- Declares convergence after CONV_SWEEPS consecutive sweeps with every |delta| < TOL, or stops at a sweep limit.
- Then freezes the buffer and drains the solution vector over a valid/ready interface.

Parameters:
N, 16, number of unknowns per sweep (index width IW = $clog2(N))
W, 32, data width of x samples (signed Q16.16)
TOL, 16, unsigned convergence tolerance in LSBs (16 = 2^-12); comparison is strict (delta < TOL)
CONV_SWEEPS, 2, consecutive converged sweeps required before draining
MAX_SWEEPS, 100, completed-sweep limit before forced drain with timeout

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
clr  input  1  synchronous start-of-problem clear (driven by solver load enable); same effect as reset
x_valid  input  1  x_in carries an estimate this cycle
x_in  input  W  signed estimate; samples arrive in index order 0..N-1, then repeat
out_valid  output  1  out_data/out_idx valid for drain
out_ready  input  1  consumer accepts on out_valid & out_ready
out_data  output  W  buffered solution value
out_idx  output  IW  index of out_data
out_last  output  1  high with out_valid when out_idx == N-1
done  output  1  drain complete; held until clr/reset
timeout  output  1  drain was forced by MAX_SWEEPS; held until clr/reset
sweep_cnt  output  8  completed sweeps, saturating at 255

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous, active-high. Reset or clr -> state COLLECT, wr_idx=0, rd_idx=0, first_sweep=1, conv_cnt=0, sweep_max=0, sweep_cnt=0. Outputs out_valid=0, out_last=0, done=0, timeout=0, out_data=0, out_idx=0. Buffer contents need not be cleared.
- clr has priority over every other event in every state; a sample arriving with clr is dropped.
- States: COLLECT -> DRAIN -> DONE -> (clr) COLLECT.
- COLLECT, sample accepted (x_valid=1):
  - Read old = buf[wr_idx] combinationally and write buf[wr_idx] <= x_in on the same edge.
  - delta = |x_in - old|, computed at W+1 bits signed, then the absolute value saturated to W-bit unsigned (max 0xFFFF_FFFF).
  - The running sweep maximum includes the current sample: smax_next = max(sweep_max, delta); sweep_max resets to 0 at sweep start.
  - wr_idx increments and wraps N-1 -> 0.
- Sweep end (accepted sample with wr_idx == N-1), evaluated on the same edge:
  - sweep_cnt += 1 (saturating); first_sweep <= 0.
  - sweep_ok = !first_sweep && (smax_next < TOL).
  - conv_cnt <= sweep_ok ? conv_cnt+1 : 0.
  - If sweep_ok && conv_cnt+1 == CONV_SWEEPS: state <= DRAIN, timeout stays 0.
  - Else if sweep_cnt+1 == MAX_SWEEPS: state <= DRAIN, timeout <= 1.
- Latency: out_valid rises the cycle after the final qualifying sample.
- DRAIN:
  - x_valid is ignored and the buffer is frozen.
  - out_valid=1, out_data=buf[rd_idx], out_idx=rd_idx, out_last=(rd_idx==N-1).
  - On out_ready, rd_idx increments. While out_ready=0, out_data, out_idx and out_last hold stable.
  - A handshake with out_last -> state DONE.
- DONE: out_valid=0, done=1, timeout holds its value, x_valid is ignored. The block stays in DONE until clr or reset.
- Gaps: x_valid=0 cycles in COLLECT change nothing; the index does not advance.

Test Plan:
1. Constant values: feed 16 values of k*0x0001_0000 for three sweeps, out_ready=1 -> sweep 1 not counted, sweeps 2-3 converge. out_valid rises 1 cycle after sample 48, 16 beats are output in index order with out_last on beat 16, then done=1, timeout=0, sweep_cnt=3.
2. Tolerance boundary: same as scenario 1 but index 5 differs by 16 LSB in sweep 3 -> no drain (conv_cnt resets). Repeat with a 15 LSB difference -> drain after sweep 3.
3. Backpressure: out_ready=0 for 5 cycles at beat 7 -> out_idx=7 and out_data held stable, no beat skipped or repeated; 16 total handshakes.
4. Timeout: alternate every sweep between all-0 and all-0x0000_0100 -> after sweep 100, drain with timeout=1 and data = all-0x0000_0100 (sweep 100 values).
5. Overflow/saturation: previous value 0x7FFF_FFFF, new value 0x8000_0000 -> delta saturates to 0xFFFF_FFFF, sweep not converged, conv_cnt=0.
6. clr mid-drain at beat 4 (and separately, reset mid-COLLECT) -> next cycle out_valid=0, done=0, timeout=0, sweep_cnt=0. A fresh scenario 1 then passes unchanged.
